// File: rtl/sse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sse_pkg
// Description : Shared word width, default watchdog limit and feeder FSM state
//               encoding for the SSE sample feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package sse_pkg;

    localparam int WORD            = 32;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/sse_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : sse_sample_ram
// Description : Two DEPTH x WORD sample banks with one bank-selected write
//               port and a shared-address synchronous read of both banks.
//               The read registers are the A/B pair presented to the engine.
// Revision    : 1.0 - initial release
// ============================================================================
module sse_sample_ram
    import sse_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  logic            i_wr_sel,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [WORD-1:0] i_wr_data,
    input  logic            i_rd_en,
    input  logic [AW-1:0]   i_rd_addr,
    output logic [WORD-1:0] o_rd_a,
    output logic [WORD-1:0] o_rd_b
);

    logic [WORD-1:0] r_bank_a [DEPTH];
    logic [WORD-1:0] r_bank_b [DEPTH];
    logic [WORD-1:0] r_rd_a;
    logic [WORD-1:0] r_rd_b;

    // Bank write; storage is deliberately unreset so samples survive rst.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (i_wr_sel) begin
                r_bank_b[i_wr_addr] <= i_wr_data;
            end else begin
                r_bank_a[i_wr_addr] <= i_wr_data;
            end
        end
    end

    // Read registers load only on request and otherwise hold the current pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else if (i_rd_en) begin
            r_rd_a <= r_bank_a[i_rd_addr];
            r_rd_b <= r_bank_b[i_rd_addr];
        end
    end

    assign o_rd_a = r_rd_a;
    assign o_rd_b = r_rd_b;

endmodule
`default_nettype wire

// File: rtl/sse_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sse_sample_feeder
// Description : Streams stored A/B sample pairs into the SSE engine on its
//               next requests, pulses the engine reset at run start, captures
//               the result on ready and guards the run with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module sse_sample_feeder
    import sse_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [WORD-1:0] wr_data,
    input  logic [AW:0]     len,
    input  logic            go,
    output logic [WORD-1:0] A,
    output logic [WORD-1:0] B,
    output logic            stop,
    output logic            sse_rst,
    input  logic            next,
    input  logic            ready,
    input  logic [WORD-1:0] Y,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] result,
    output logic            err
);

    localparam int         WDW     = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    feeder_state_t   r_state;
    feeder_state_t   w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW:0]     r_len;
    logic [WDW-1:0]  r_wdog;
    logic            r_stop;
    logic            r_sse_rst;
    logic            r_busy;
    logic            r_done;
    logic [WORD-1:0] r_result;
    logic            r_err;

    logic            w_load;
    logic            w_adv;
    logic            w_capture;
    logic            w_timeout;
    logic            w_reject;
    logic            w_len_bad;
    logic            w_can_adv;
    logic            w_wr;
    logic [AW:0]     w_idx_inc;
    logic [AW:0]     w_idx_inc2;
    logic [AW-1:0]   w_rd_addr;

    assign w_len_bad  = (len == '0) || (len > c_depth);
    assign w_idx_inc  = {1'b0, r_idx} + (AW+1)'(1);
    assign w_idx_inc2 = w_idx_inc + (AW+1)'(1);
    // idx < len-1 rewritten as idx+1 < len to avoid underflow
    assign w_can_adv  = (w_idx_inc < r_len);
    assign w_wr       = wr_en && (r_state == S_IDLE);
    assign w_rd_addr  = w_load ? '0 : w_idx_inc[AW-1:0];

    // Next-state and per-edge action decode; ready beats next, next beats the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    if (w_len_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (next && w_can_adv) begin
                    w_adv = 1'b1;
                end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, index, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_wdog    <= '0;
            r_stop    <= 1'b0;
            r_sse_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sse_rst <= w_load;
            r_done    <= w_capture;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_load) begin
                r_idx  <= '0;
                r_len  <= len;
                r_stop <= (len == (AW+1)'(1));
                r_wdog <= '0;
            end else if (w_adv) begin
                r_idx  <= r_idx + AW'(1);
                r_stop <= (w_idx_inc2 == r_len);
                r_wdog <= '0;
            end else if ((r_state == S_STREAM) && !w_capture && !w_timeout) begin
                r_wdog <= r_wdog + WDW'(1);
            end
            if (w_capture) begin
                r_result <= Y;
            end
            if (w_load) begin
                r_err <= 1'b0;
            end else if (w_reject || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    sse_sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_sel  (wr_sel),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_load || w_adv),
        .i_rd_addr (w_rd_addr),
        .o_rd_a    (A),
        .o_rd_b    (B)
    );

    assign stop    = r_stop;
    assign sse_rst = r_sse_rst;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign err     = r_err;

endmodule
`default_nettype wire
